mem_port_arbiter: RTL

Arbitrates a single shared memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage: loads/stores) of the multi-cycle RISC core. Latches the winning request, drives the memory port until the memory signals ready, then returns read data with a one-cycle done pulse. It sits between the control unit's `enIF`/`enMem` stage logic and a unified instruction/data memory with variable latency.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; data has priority.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic              ifDone,
   output logic [DATA_W-1:0] ifRdata,
   input  logic              dReq,
   input  logic              dWe,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   output logic              dDone,
   output logic [DATA_W-1:0] dRdata,
   output logic              memEn,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memReady,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D, DONE} state_t;

   state_t              state_q, state_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_done_q, if_done_d;
   logic                d_done_q, d_done_d;
   logic                fetch_turn;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt_q, starve_cnt_d;

   assign fetch_turn = (starve_cnt_q == 4'(STARVE_LIMIT)) && ifReq && dReq;

   // Counts data grants that overtook a waiting fetch; any IDLE without a fetch pending forgets history.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == IDLE) begin
         if (!ifReq)
            starve_cnt_d = 4'd0;
         else if (dReq && !fetch_turn)
            starve_cnt_d = starve_cnt_q + 4'd1;
         else
            starve_cnt_d = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         starve_cnt_q <= 4'd0;
      else
         starve_cnt_q <= starve_cnt_d;
   end
`else
   // Strict data priority: STARVE_LIMIT has no effect in this build.
   assign fetch_turn = 1'b0 & (STARVE_LIMIT == 0);
`endif

   always_comb begin
      state_d     = state_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (dReq && !fetch_turn) begin
               state_d     = ACC_D;
               mem_en_d    = 1'b1;
               mem_we_d    = dWe;
               mem_addr_d  = dAddr;
               mem_wdata_d = dWdata;
            end else if (ifReq) begin
               state_d    = ACC_IF;
               mem_en_d   = 1'b1;
               mem_addr_d = ifAddr;
            end
         end
         ACC_IF: begin
            if (memReady) begin
               state_d    = DONE;
               if_rdata_d = memRdata;
               if_done_d  = 1'b1;
            end else begin
               mem_en_d = 1'b1;
            end
         end
         ACC_D: begin
            // mem_we_q still holds the granted dWe here; it only clears on entry to DONE.
            if (memReady) begin
               state_d  = DONE;
               d_done_d = 1'b1;
               if (!mem_we_q)
                  d_rdata_d = memRdata;
            end else begin
               mem_en_d = 1'b1;
               mem_we_d = mem_we_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
      end
   end

   assign memEn    = mem_en_q;
   assign memWe    = mem_we_q;
   assign memAddr  = mem_addr_q;
   assign memWdata = mem_wdata_q;
   assign ifRdata  = if_rdata_q;
   assign dRdata   = d_rdata_q;
   assign ifDone   = if_done_q;
   assign dDone    = d_done_q;
   assign busy     = (state_q != IDLE);

endmodule
